// File: rtl/latch_gate_ctrl.sv
// latch_gate_ctrl: sequences the data, enable and clear pins of a downstream
// transparent latch. An accepted word is presented on latch_data, the gate
// opens after setup_cycles, stays open for gate_cycles, and the data is held
// for hold_cycles after the gate closes before the next word is accepted.
// A clear request in IDLE pulses latch_aclr for one cycle.
// Optional feature macro: LATCH_GATE_CTRL_SET_EN adds a set_req input that
// pulses latch_aset for one cycle (clr_req takes priority).
module latch_gate_ctrl #(
  parameter int lpm_width    = 1,
  parameter int setup_cycles = 1,
  parameter int gate_cycles  = 1,
  parameter int hold_cycles  = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [lpm_width-1:0] in_data,
  input  logic                 clr_req,
`ifdef LATCH_GATE_CTRL_SET_EN
  input  logic                 set_req,
`endif
  output logic [lpm_width-1:0] latch_data,
  output logic                 latch_gate,
  output logic                 latch_aclr,
  output logic                 latch_aset,
  output logic                 busy
);

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [3:0] SETUP_LOAD = 4'(setup_cycles - 1);
  localparam logic [3:0] GATE_LOAD  = 4'(gate_cycles - 1);
  localparam logic [3:0] HOLD_LOAD  = 4'(hold_cycles - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_OPEN,
    ST_HOLD,
    ST_CLEAR
`ifdef LATCH_GATE_CTRL_SET_EN
    ,
    ST_SET
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [lpm_width-1:0]   latch_data_q, latch_data_d;
  logic                   latch_gate_q, latch_gate_d;
  logic                   latch_aclr_q, latch_aclr_d;
  logic                   set_pending;

`ifdef LATCH_GATE_CTRL_SET_EN
  logic                   latch_aset_q, latch_aset_d;
  // A set request only counts when no clear request competes with it.
  assign set_pending = set_req & ~clr_req;
`else
  assign set_pending = 1'b0;
`endif

  // Upstream handshake: a word is taken only in IDLE when no clear/set
  // pulse is being requested in the same cycle.
  assign in_ready = (state_q == ST_IDLE) & ~clr_req & ~set_pending;
  assign busy     = (state_q != ST_IDLE);

  // Next-state and next-output logic for the sequencing FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; an unassigned path in always_comb infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    latch_data_d = latch_data_q;
    latch_gate_d = latch_gate_q;
    latch_aclr_d = 1'b0;
`ifdef LATCH_GATE_CTRL_SET_EN
    latch_aset_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        latch_gate_d = 1'b0;
        if (clr_req) begin
          latch_aclr_d = 1'b1;
          state_d      = ST_CLEAR;
        end else if (set_pending) begin
`ifdef LATCH_GATE_CTRL_SET_EN
          latch_aset_d = 1'b1;
          state_d      = ST_SET;
`endif
        end else if (in_valid) begin
          latch_data_d = in_data;
          cnt_d        = SETUP_LOAD;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          latch_gate_d = 1'b1;
          cnt_d        = GATE_LOAD;
          state_d      = ST_OPEN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_OPEN: begin
        if (cnt_q == 4'd0) begin
          latch_gate_d = 1'b0;
          cnt_d        = HOLD_LOAD;
          state_d      = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CLEAR: begin
        state_d = ST_IDLE;
      end
`ifdef LATCH_GATE_CTRL_SET_EN
      ST_SET: begin
        state_d = ST_IDLE;
      end
`endif
      default: begin
        state_d      = ST_IDLE;
        latch_gate_d = 1'b0;
      end
    endcase
  end

  // State, counter and registered latch-pin outputs; reset aborts any transfer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      latch_data_q <= '0;
      latch_gate_q <= 1'b0;
      latch_aclr_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      latch_data_q <= latch_data_d;
      latch_gate_q <= latch_gate_d;
      latch_aclr_q <= latch_aclr_d;
    end
  end

`ifdef LATCH_GATE_CTRL_SET_EN
  // Registered asynchronous-set pulse for the downstream latch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      latch_aset_q <= 1'b0;
    end else begin
      latch_aset_q <= latch_aset_d;
    end
  end
  assign latch_aset = latch_aset_q;
`else
  assign latch_aset = 1'b0;
`endif

  assign latch_data = latch_data_q;
  assign latch_gate = latch_gate_q;
  assign latch_aclr = latch_aclr_q;

endmodule

// File: tb/tb_latch_gate_ctrl.sv
// Testbench for latch_gate_ctrl. Instance A uses setup=2, gate=3, hold=1 with
// an 8-bit word; instance B uses the default timing with an 8-bit word.
// Build with LATCH_GATE_CTRL_SET_EN defined to also exercise set_req.
module tb_latch_gate_ctrl;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;

  logic         a_valid, a_ready, a_clr, a_gate, a_aclr, a_aset, a_busy;
  logic [W-1:0] a_data, a_ldata;
  logic         b_valid, b_ready, b_clr, b_gate, b_aclr, b_aset, b_busy;
  logic [W-1:0] b_data, b_ldata;
`ifdef LATCH_GATE_CTRL_SET_EN
  logic         a_set, b_set;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  latch_gate_ctrl #(
    .lpm_width(W), .setup_cycles(2), .gate_cycles(3), .hold_cycles(1)
  ) dut_a (
    .clock(clock), .reset_n(reset_n),
    .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
    .clr_req(a_clr),
`ifdef LATCH_GATE_CTRL_SET_EN
    .set_req(a_set),
`endif
    .latch_data(a_ldata), .latch_gate(a_gate), .latch_aclr(a_aclr),
    .latch_aset(a_aset), .busy(a_busy)
  );

  latch_gate_ctrl #(
    .lpm_width(W)
  ) dut_b (
    .clock(clock), .reset_n(reset_n),
    .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .clr_req(b_clr),
`ifdef LATCH_GATE_CTRL_SET_EN
    .set_req(b_set),
`endif
    .latch_data(b_ldata), .latch_gate(b_gate), .latch_aclr(b_aclr),
    .latch_aset(b_aset), .busy(b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One row per clock cycle of instance A: inputs driven for that cycle and
  // the outputs expected during it (before the edge that ends the cycle).
  typedef struct {
    logic         valid;
    logic [W-1:0] data;
    logic         clr;
    logic         ready;
    logic         gate;
    logic         aclr;
    logic [W-1:0] ldata;
    logic         busy;
  } vec_t;

  vec_t vecs [12];

  // Expected per-cycle traces for instance B (setup=gate=hold=1).
  logic [8:0] b_ready_tr, b_gate_tr, b_busy_tr;
  logic [W-1:0] b_ldata_tr [9];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int acc_cycle [2];
    bit seen;

    //            valid  data   clr   ready gate aclr ldata  busy
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0}; // accept A5
    vecs[1]  = '{1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1}; // SETUP, data wiggles
    vecs[2]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1}; // valid while busy
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1}; // gate opens
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1}; // clr in OPEN ignored
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1}; // HOLD
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0}; // ready again
    vecs[8]  = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0}; // clr beats valid
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1}; // CLEAR pulse
    vecs[10] = '{1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0}; // accept C3
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1};

    // Bit k = cycle k, starting with the cycle 0x11 is offered.
    b_ready_tr = 9'b1_0001_0001;
    b_gate_tr  = 9'b0_0100_0100;
    b_busy_tr  = 9'b0_1110_1110;
    b_ldata_tr = '{8'h00, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};

    a_valid = 1'b0; a_data = '0; a_clr = 1'b0;
    b_valid = 1'b0; b_data = '0; b_clr = 1'b0;
`ifdef LATCH_GATE_CTRL_SET_EN
    a_set = 1'b0; b_set = 1'b0;
`endif

    // Reset state.
    repeat (2) @(negedge clock);
    check("reset_gate", 32'(a_gate), 32'd0);
    check("reset_busy", 32'(a_busy), 32'd0);
    check("reset_ldata", 32'(a_ldata), 32'd0);
    check("reset_aclr", 32'(a_aclr), 32'd0);
    check("reset_aset", 32'(a_aset), 32'd0);
    check("reset_ready", 32'(a_ready), 32'd1);

    // Release, then the table starts on the first edge after release.
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a_valid = vecs[i].valid;
      a_data  = vecs[i].data;
      a_clr   = vecs[i].clr;
      #1;
      check($sformatf("vec%0d_ready", i), 32'(a_ready), 32'(vecs[i].ready));
      check($sformatf("vec%0d_gate", i), 32'(a_gate), 32'(vecs[i].gate));
      check($sformatf("vec%0d_aclr", i), 32'(a_aclr), 32'(vecs[i].aclr));
      check($sformatf("vec%0d_ldata", i), 32'(a_ldata), 32'(vecs[i].ldata));
      check($sformatf("vec%0d_busy", i), 32'(a_busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_aset", i), 32'(a_aset), 32'd0);
      check($sformatf("vec%0d_gate_aclr_excl", i), 32'(a_gate & a_aclr), 32'd0);
      @(negedge clock);
    end
    a_valid = 1'b0; a_data = '0; a_clr = 1'b0;

    // Asynchronous reset in the middle of the C3 gate pulse.
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      #1;
      if (a_gate) seen = 1'b1;
      else @(negedge clock);
    end
    check("mid_open_gate_seen", 32'(seen), 32'd1);
    @(negedge clock);
    #1;
    check("mid_open_gate_before_rst", 32'(a_gate), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_gate", 32'(a_gate), 32'd0);
    check("async_rst_busy", 32'(a_busy), 32'd0);
    check("async_rst_ldata", 32'(a_ldata), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(a_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      #1;
      check($sformatf("post_rst_idle_gate%0d", k), 32'(a_gate), 32'd0);
      check($sformatf("post_rst_idle_busy%0d", k), 32'(a_busy), 32'd0);
    end

    // Instance B: back-to-back words with in_valid held high.
    @(negedge clock);
    acc = 0;
    acc_cycle[0] = -1;
    acc_cycle[1] = -1;
    for (int k = 0; k < 9; k++) begin
      b_valid = (acc < 2);
      b_data  = (acc == 0) ? 8'h11 : 8'h22;
      #1;
      check($sformatf("b2b_ready_c%0d", k), 32'(b_ready), 32'(b_ready_tr[k]));
      check($sformatf("b2b_gate_c%0d", k), 32'(b_gate), 32'(b_gate_tr[k]));
      check($sformatf("b2b_busy_c%0d", k), 32'(b_busy), 32'(b_busy_tr[k]));
      check($sformatf("b2b_ldata_c%0d", k), 32'(b_ldata), 32'(b_ldata_tr[k]));
      check($sformatf("b2b_aclr_c%0d", k), 32'(b_aclr), 32'd0);
      check($sformatf("b2b_aset_c%0d", k), 32'(b_aset), 32'd0);
      if (b_valid && b_ready) begin
        acc_cycle[acc] = k;
        acc++;
      end
      @(negedge clock);
    end
    b_valid = 1'b0;
    check("b2b_accept_count", 32'(acc), 32'd2);
    check("b2b_second_accept_cycle", 32'(acc_cycle[1]), 32'd4);

`ifdef LATCH_GATE_CTRL_SET_EN
    // set_req alone in IDLE: one-cycle latch_aset, no accept.
    a_set = 1'b1; a_valid = 1'b1; a_data = 8'h99;
    #1;
    check("set_ready_blocked", 32'(a_ready), 32'd0);
    @(negedge clock);
    a_set = 1'b0; a_valid = 1'b0;
    #1;
    check("set_aset_high", 32'(a_aset), 32'd1);
    check("set_aclr_low", 32'(a_aclr), 32'd0);
    check("set_busy", 32'(a_busy), 32'd1);
    @(negedge clock);
    #1;
    check("set_aset_drop", 32'(a_aset), 32'd0);
    check("set_ready_back", 32'(a_ready), 32'd1);
    check("set_no_accept", 32'(a_ldata), 32'd0);
    // set_req and clr_req together: clear wins.
    a_set = 1'b1; a_clr = 1'b1;
    @(negedge clock);
    a_set = 1'b0; a_clr = 1'b0;
    #1;
    check("setclr_aclr", 32'(a_aclr), 32'd1);
    check("setclr_aset", 32'(a_aset), 32'd0);
    @(negedge clock);
    #1;
    check("setclr_aclr_drop", 32'(a_aclr), 32'd0);
    check("setclr_aset_still_low", 32'(a_aset), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
